// File: rtl/segre_mmu_dcache.sv
// Data-cache miss handler: one outstanding line fill from memory plus victim selection.
// Define SEGRE_MMU_DC_LRU_EN for true-LRU replacement; otherwise round-robin.
module segre_mmu_dcache #(
  parameter int  NUM_LANES         = 4,
  parameter int  ADDR_SIZE         = 32,
  parameter int  DCACHE_LANE_SIZE  = 128,
  parameter int  DCACHE_BYTE_SIZE  = 4,
  parameter int  LINE_LSB          = DCACHE_BYTE_SIZE,
  localparam int DCACHE_INDEX_SIZE = $clog2(NUM_LANES)
) (
  input  logic                         clk_i,
  input  logic                         rsn_i,
  input  logic                         dc_access_i,
  input  logic                         dc_miss_i,
  input  logic [ADDR_SIZE-1:0]         dc_addr_i,
  output logic                         dc_data_rdy_o,
  output logic [DCACHE_LANE_SIZE-1:0]  dc_data_o,
  output logic [DCACHE_INDEX_SIZE-1:0] dc_lru_index_o,
  output logic                         mem_req_o,
  output logic [ADDR_SIZE-1:0]         mem_addr_o,
  input  logic                         mem_gnt_i,
  input  logic                         mem_rvalid_i,
  input  logic [DCACHE_LANE_SIZE-1:0]  mem_rdata_i,
  output logic                         busy_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

  state_e                        state_q;
  logic                          mem_req_q;
  logic                          busy_q;
  logic                          rdy_q;
  logic [ADDR_SIZE-1:0]          mem_addr_q;
  logic [ADDR_SIZE-1:0]          addr_d;
  logic [DCACHE_LANE_SIZE-1:0]   data_q;
  logic [DCACHE_INDEX_SIZE-1:0]  victim_q;
  logic [DCACHE_INDEX_SIZE-1:0]  victim_s;

  always_comb begin
    addr_d = dc_addr_i;
    addr_d[LINE_LSB-1:0] = '0;
  end

  always_ff @(posedge clk_i) begin
    if (!rsn_i) begin
      state_q    <= IDLE;
      mem_req_q  <= 1'b0;
      busy_q     <= 1'b0;
      rdy_q      <= 1'b0;
      mem_addr_q <= '0;
      data_q     <= '0;
      victim_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (dc_miss_i) begin
            mem_addr_q <= addr_d;
            victim_q   <= victim_s;
            mem_req_q  <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= REQ;
          end
        end
        REQ: begin
          if (mem_gnt_i) begin
            mem_req_q <= 1'b0;
            state_q   <= WAIT;
          end
        end
        WAIT: begin
          if (mem_rvalid_i) begin
            data_q  <= mem_rdata_i;
            rdy_q   <= 1'b1;
            state_q <= RESP;
          end
        end
        RESP: begin
          rdy_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          mem_req_q <= 1'b0;
          busy_q    <= 1'b0;
          rdy_q     <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

`ifdef SEGRE_MMU_DC_LRU_EN
  logic [DCACHE_INDEX_SIZE-1:0] age_q [NUM_LANES];
  logic [DCACHE_INDEX_SIZE-1:0] age_d [NUM_LANES];
  logic                         upd_en_s;
  logic [DCACHE_INDEX_SIZE-1:0] upd_idx_s;

  // A fill in RESP takes priority over a coincident hit.
  always_comb begin
    upd_en_s  = 1'b0;
    upd_idx_s = '0;
    if (state_q == RESP) begin
      upd_en_s  = 1'b1;
      upd_idx_s = victim_q;
    end else if (dc_access_i && !dc_miss_i) begin
      upd_en_s  = 1'b1;
      upd_idx_s = dc_addr_i[DCACHE_INDEX_SIZE-1:0];
    end else begin
      upd_en_s  = 1'b0;
    end
  end

  always_comb begin
    victim_s = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      age_d[i] = age_q[i];
      if (age_q[i] == DCACHE_INDEX_SIZE'(NUM_LANES - 1)) victim_s = DCACHE_INDEX_SIZE'(i);
      if (upd_en_s) begin
        if (DCACHE_INDEX_SIZE'(i) == upd_idx_s) age_d[i] = '0;
        else if (age_q[i] < age_q[upd_idx_s]) age_d[i] = age_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NUM_LANES; i++) begin
      if (!rsn_i) age_q[i] <= DCACHE_INDEX_SIZE'(i);
      else        age_q[i] <= age_d[i];
    end
  end
`else
  logic [DCACHE_INDEX_SIZE-1:0] ptr_q;
  logic                         unused_hit_s;

  assign unused_hit_s = dc_access_i;
  assign victim_s     = ptr_q;

  always_ff @(posedge clk_i) begin
    if (!rsn_i) begin
      ptr_q <= '0;
    end else if (state_q == RESP) begin
      if (ptr_q == DCACHE_INDEX_SIZE'(NUM_LANES - 1)) ptr_q <= '0;
      else                                            ptr_q <= ptr_q + 1'b1;
    end
  end
`endif

  // While a fill is in flight the victim is frozen; in IDLE it tracks replacement state.
  assign dc_lru_index_o = (state_q == IDLE) ? victim_s : victim_q;
  assign dc_data_rdy_o  = rdy_q;
  assign dc_data_o      = data_q;
  assign mem_req_o      = mem_req_q;
  assign mem_addr_o     = mem_addr_q;
  assign busy_o         = busy_q;

endmodule

// File: tb/tb_segre_mmu_dcache.sv
// Directed + randomized bench for segre_mmu_dcache with a recency-list / counter replacement model.
module tb_segre_mmu_dcache;
  localparam int NL = 4;

  logic         clk = 1'b0;
  logic         rsn;
  logic         dc_access;
  logic         dc_miss;
  logic [31:0]  dc_addr;
  logic         dc_data_rdy;
  logic [127:0] dc_data;
  logic [1:0]   dc_lru_index;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_gnt;
  logic         mem_rvalid;
  logic [127:0] mem_rdata;
  logic         busy;

  int total = 0;
  int bad   = 0;

  int rec_q[$];
  int rr_cnt;

  segre_mmu_dcache dut (
    .clk_i(clk), .rsn_i(rsn), .dc_access_i(dc_access), .dc_miss_i(dc_miss),
    .dc_addr_i(dc_addr), .dc_data_rdy_o(dc_data_rdy), .dc_data_o(dc_data),
    .dc_lru_index_o(dc_lru_index), .mem_req_o(mem_req), .mem_addr_o(mem_addr),
    .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void mdl_reset();
    rec_q = {};
    for (int i = 0; i < NL; i++) rec_q.push_back(i);
    rr_cnt = 0;
  endfunction

  function automatic int mdl_victim();
`ifdef SEGRE_MMU_DC_LRU_EN
    return rec_q[rec_q.size() - 1];
`else
    return rr_cnt % NL;
`endif
  endfunction

  // Move the touched line to the most-recently-used end of the list.
  function automatic void mdl_touch(input int idx);
    for (int i = 0; i < rec_q.size(); i++) begin
      if (rec_q[i] == idx) begin
        rec_q.delete(i);
        break;
      end
    end
    rec_q.push_front(idx);
  endfunction

  function automatic void mdl_hit(input int idx);
`ifdef SEGRE_MMU_DC_LRU_EN
    mdl_touch(idx);
`endif
  endfunction

  function automatic void mdl_fill(input int v);
    mdl_touch(v);
    rr_cnt++;
  endfunction

  task automatic clear_inputs();
    dc_access = 1'b0; dc_miss = 1'b0; dc_addr = 32'd0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 128'd0;
  endtask

  task automatic noise(input bit allow_hit);
    dc_access = 1'($urandom % 2);
    dc_miss   = 1'($urandom % 2);
    dc_addr   = 32'($urandom_range(0, NL - 1));
    if (allow_hit && dc_access && !dc_miss) mdl_hit(int'(dc_addr));
  endtask

  task automatic do_reset(input int n);
    rsn = 1'b0;
    for (int i = 0; i < n; i++) begin
      noise(1'b0);
      mem_gnt = 1'($urandom % 2); mem_rvalid = 1'($urandom % 2);
      tick();
    end
    clear_inputs();
    rsn = 1'b1;
    mdl_reset();
  endtask

  task automatic do_fill(input logic [31:0] a, input logic [127:0] d, input int gd, input int rd,
                         input bit noisy);
    logic [31:0] ea;
    int ev;
    ea = a & 32'hFFFF_FFF0;
    ev = mdl_victim();
    chk("idle_victim", dc_lru_index, 128'(ev));
    chk("idle_busy", busy, 128'd0);
    dc_access = 1'b1; dc_miss = 1'b1; dc_addr = a;
    tick();
    clear_inputs();
    for (int k = 0; k <= gd; k++) begin
      chk("req_valid", mem_req, 128'd1);
      chk("req_addr", mem_addr, 128'(ea));
      chk("req_busy", busy, 128'd1);
      chk("req_victim", dc_lru_index, 128'(ev));
      chk("req_rdy", dc_data_rdy, 128'd0);
      if (noisy) begin
        noise(1'b1);
        mem_rvalid = 1'($urandom % 2);
        mem_rdata  = {4{$urandom}};
      end
      mem_gnt = (k == gd);
      tick();
    end
    clear_inputs();
    for (int k = 0; k <= rd; k++) begin
      chk("wait_req", mem_req, 128'd0);
      chk("wait_rdy", dc_data_rdy, 128'd0);
      chk("wait_busy", busy, 128'd1);
      chk("wait_victim", dc_lru_index, 128'(ev));
      if (noisy) begin
        noise(1'b1);
        mem_gnt = 1'($urandom % 2);
      end
      mem_rvalid = (k == rd);
      mem_rdata  = (k == rd) ? d : ~d;
      tick();
    end
    clear_inputs();
    chk("resp_rdy", dc_data_rdy, 128'd1);
    chk("resp_data", dc_data, d);
    chk("resp_victim", dc_lru_index, 128'(ev));
    chk("resp_busy", busy, 128'd1);
    chk("resp_req", mem_req, 128'd0);
    if (noisy) begin
      noise(1'b0);
      mem_rvalid = 1'b1;
    end
    mdl_fill(ev);
    tick();
    clear_inputs();
    chk("post_rdy", dc_data_rdy, 128'd0);
    chk("post_busy", busy, 128'd0);
    chk("post_req", mem_req, 128'd0);
  endtask

  initial begin
    logic [127:0] rd_data;
    clear_inputs();
    rsn = 1'b1;
    mdl_reset();

    // Reset state
    do_reset(2);
    chk("rst_rdy", dc_data_rdy, 128'd0);
    chk("rst_req", mem_req, 128'd0);
    chk("rst_busy", busy, 128'd0);
    chk("rst_data", dc_data, 128'd0);
    chk("rst_addr", mem_addr, 128'd0);
`ifdef SEGRE_MMU_DC_LRU_EN
    chk("rst_victim", dc_lru_index, 128'd3);
`else
    chk("rst_victim", dc_lru_index, 128'd0);
`endif

    // Minimum-latency fill
    rd_data = {4{32'hA5A5_A5A5}};
    do_fill(32'h0000_1234, rd_data, 0, 0, 1'b0);
    chk("min_lat_addr", mem_addr, 128'h1230);

    // Delayed grant, then back-to-back fill in the next IDLE cycle
    do_fill(32'h0000_8F7C, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677, 3, 2, 1'b0);
    do_fill(32'hFFFF_FFFF, 128'hDEAD_BEEF, 1, 0, 1'b1);

    // Replacement order from a clean reset
    do_reset(1);
    for (int i = 0; i < 3; i++) begin
      dc_access = 1'b1; dc_miss = 1'b0;
      dc_addr = (i == 0) ? 32'd3 : 32'(i - 1);
      mdl_hit(int'(dc_addr));
      tick();
    end
    clear_inputs();
`ifdef SEGRE_MMU_DC_LRU_EN
    chk("lru_victim_after_hits", dc_lru_index, 128'd2);
`else
    chk("rr_victim_first", dc_lru_index, 128'd0);
`endif
    do_fill(32'h0000_0040, 128'h1, 0, 0, 1'b0);
`ifndef SEGRE_MMU_DC_LRU_EN
    chk("rr_victim_second", dc_lru_index, 128'd1);
`endif
    do_fill(32'h0000_0080, 128'h2, 0, 0, 1'b0);

    // Reset while waiting for read data abandons the fill
    dc_access = 1'b1; dc_miss = 1'b1; dc_addr = 32'h0000_5550;
    tick();
    clear_inputs();
    mem_gnt = 1'b1;
    tick();
    clear_inputs();
    chk("abort_in_wait", busy, 128'd1);
    do_reset(1);
    mem_rvalid = 1'b1; mem_rdata = 128'hBAD;
    for (int k = 0; k < 3; k++) begin
      tick();
      mem_rvalid = 1'b0;
      chk("abort_rdy", dc_data_rdy, 128'd0);
      chk("abort_busy", busy, 128'd0);
      chk("abort_req", mem_req, 128'd0);
      chk("abort_victim", dc_lru_index, 128'(mdl_victim()));
    end

    // Randomized fills with hits, stray misses and stray handshakes
    for (int n = 0; n < 25; n++) begin
      for (int h = $urandom_range(0, 3); h > 0; h--) begin
        dc_access = 1'b1; dc_miss = 1'b0;
        dc_addr = 32'($urandom_range(0, NL - 1));
        mdl_hit(int'(dc_addr));
        tick();
      end
      clear_inputs();
      do_fill($urandom, {$urandom, $urandom, $urandom, $urandom},
              $urandom_range(0, 4), $urandom_range(0, 4), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
